retire_rat: RTL and testbench
=============================

Name: retire_rat

Overview:
- Retirement register alias table (RRAT) for the rename stage.
- Accepts up to WAYS retiring instructions per cycle from the ROB and maintains the architectural-to-physical map.
- Drives the free-list retire interface: new mapping entering, old mapping leaving, per-way enable. Ways after a mis-branch are never enabled.
- On exception, provides the committed map for RAT recovery.

Parameters:
- WAYS, 4, superscalar retire width.
- PRF, 64, physical register count; PRF_IDX_W = $clog2(PRF).
- ARCH, 32, architectural register count; ARCH_IDX_W = 5.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- retire_valid  in  WAYS  per-way retire strobe from ROB; contiguous from way 0.
- retire_has_dest  in  WAYS  way writes a destination register.
- retire_arch  in  WAYS x ARCH_IDX_W  architectural destination.
- retire_phys  in  WAYS x PRF_IDX_W  physical destination allocated at rename.
- retire_mispred  in  WAYS  way is a mis-predicted branch. The way itself retires; younger ways are squashed.
- wr_en_RRAT  out  WAYS  to free list, per-way commit enable.
- reg_idx_wr_RRAT_new  out  WAYS x PRF_IDX_W  mapping entering RRAT.
- reg_idx_wr_RRAT_old  out  WAYS x PRF_IDX_W  mapping leaving RRAT (to be freed).
- except  out  1  mis-branch retired; aligned with the wr_en_RRAT of the same group.
- rrat_map  out  ARCH x PRF_IDX_W  committed map, for RAT recovery.

Behaviour:
- Reset (async): map[i] = i for all i, matching free-list reset where PRF 0..31 are not free. All outputs 0 except rrat_map.
- Effective enable per way i:
  - eff[i] = retire_valid[i] & retire_has_dest[i] & (retire_arch[i] != 0) & no retire_mispred[k] for any k < i.
  - A mispredicting way with a destination (JAL/JALR) is itself enabled.
- Old mapping for way j:
  - If some earlier way i < j has eff[i] and the same arch reg, old = retire_phys of the highest such i.
  - Otherwise old = map[retire_arch[j]] (pre-update).
- Map update: map[arch] <= retire_phys of the highest enabled way writing that arch. Older ways in the group are overwritten.
- Output timing:
  - All free-list outputs are registered, one-cycle latency from the retire inputs.
  - except <= OR over i of (retire_valid[i] & retire_mispred[i]), registered in the same cycle.
- rrat_map reflects the post-update map in the cycle except is high. Free list and RAT consume it together.
- x0: never remapped. Retire to arch 0 gives wr_en 0.
- Invalid gaps (valid not contiguous) are treated per-way; no assumption beyond the squash rule.
- No back-pressure: every presented group is accepted each cycle.
- Reset mid-group: the pending registered outputs are cleared, map returns to identity, and the group is lost.

Optional Feature:
- RRAT_DUP_CHECK_EN: adds output dup_err (1 bit, sticky until reset).
  - Sets when an enabled retire_phys equals any currently mapped physical register not being replaced in the same group.
  - Sets when two enabled ways in one group carry the same retire_phys.
  - Without the macro: no port, no logic.

Decomposition:
- Package rename_pkg: ARCH, ARCH_IDX_W, PRF_IDX_W, and typedefs arch_idx_t, phys_idx_t, map_t (ARCH x phys_idx_t).
- One combinational sub-module, retire_bypass: computes eff[] and per-way old indices from map and group inputs. It is instantiated once.
- State and output registers stay in retire_rat.

Test Plan:
- Reset, then one retire: way0 arch 5 -> phys 40 -> next cycle wr_en=0001, new[0]=40, old[0]=5; rrat_map[5]=40.
- Intra-group collision: ways 0..2 all arch 7 with phys 33,34,35 -> old = {7,33,34}, new = {33,34,35}; map[7]=35.
- Mis-branch on way1 with dest arch 1 -> phys 50, ways 2-3 valid -> wr_en=0011, except=1, map[1]=50, ways 2-3 map unchanged.
- Arch x0 retire with phys 45 -> wr_en bit 0, map[0] stays 0.
- Async reset asserted between clock edges after a retire group -> outputs 0 immediately, map identity, nothing emitted at next edge.
- RRAT_DUP_CHECK_EN: retire phys 3 to arch 9 (phys 3 still mapped to arch 3) -> dup_err=1 and holds until reset.

Source files
------------

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared widths and types for the retirement register alias table
package rename_pkg;
    localparam int WAYS       = 4;
    localparam int PRF        = 64;
    localparam int PRF_IDX_W  = $clog2(PRF);
    localparam int ARCH       = 32;
    localparam int ARCH_IDX_W = 5;

    typedef logic [ARCH_IDX_W-1:0] arch_idx_t;
    typedef logic [PRF_IDX_W-1:0]  phys_idx_t;
    typedef phys_idx_t [ARCH-1:0]  map_t;
endpackage

// File: rtl/retire_bypass.sv
// rtl/retire_bypass.sv - per-way commit enables and old-mapping lookup with intra-group bypass
import rename_pkg::*;

module retire_bypass (
    input  logic [WAYS-1:0]             retire_valid,
    input  logic [WAYS-1:0]             retire_has_dest,
    input  arch_idx_t [WAYS-1:0]        retire_arch,
    input  phys_idx_t [WAYS-1:0]        retire_phys,
    input  logic [WAYS-1:0]             retire_mispred,
    input  map_t                        map,
    output logic [WAYS-1:0]             eff,
    output phys_idx_t [WAYS-1:0]        old_phys
);
    logic squash;

    always_comb begin
        eff    = '0;
        squash = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            eff[i] = retire_valid[i] & retire_has_dest[i] &
                     (retire_arch[i] != '0) & ~squash;
            // A mispredicting way still commits; only younger ways are squashed.
            if (retire_mispred[i]) begin
                squash = 1'b1;
            end
        end
    end

    always_comb begin
        old_phys = '0;
        for (int j = 0; j < WAYS; j++) begin
            old_phys[j] = map[retire_arch[j]];
            // Ascending scan leaves the youngest older writer of the same arch reg.
            for (int i = 0; i < WAYS; i++) begin
                if ((i < j) && eff[i] && (retire_arch[i] == retire_arch[j])) begin
                    old_phys[j] = retire_phys[i];
                end
            end
        end
    end
endmodule

// File: rtl/retire_rat.sv
// rtl/retire_rat.sv - retirement RAT with registered free-list outputs; optional RRAT_DUP_CHECK_EN adds dup_err
import rename_pkg::*;

module retire_rat (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WAYS-1:0]             retire_valid,
    input  logic [WAYS-1:0]             retire_has_dest,
    input  arch_idx_t [WAYS-1:0]        retire_arch,
    input  phys_idx_t [WAYS-1:0]        retire_phys,
    input  logic [WAYS-1:0]             retire_mispred,
    output logic [WAYS-1:0]             wr_en_RRAT,
    output phys_idx_t [WAYS-1:0]        reg_idx_wr_RRAT_new,
    output phys_idx_t [WAYS-1:0]        reg_idx_wr_RRAT_old,
    output logic                        except,
`ifdef RRAT_DUP_CHECK_EN
    output logic                        dup_err,
`endif
    output map_t                        rrat_map
);
    map_t                  map_q, map_d;
    logic [WAYS-1:0]       wr_en_q, wr_en_d;
    phys_idx_t [WAYS-1:0]  new_q, new_d;
    phys_idx_t [WAYS-1:0]  old_q, old_d;
    logic                  except_q, except_d;
    logic [WAYS-1:0]       eff;
    phys_idx_t [WAYS-1:0]  old_phys;

    retire_bypass u_bypass (
        .retire_valid    (retire_valid),
        .retire_has_dest (retire_has_dest),
        .retire_arch     (retire_arch),
        .retire_phys     (retire_phys),
        .retire_mispred  (retire_mispred),
        .map             (map_q),
        .eff             (eff),
        .old_phys        (old_phys)
    );

    always_comb begin
        map_d    = map_q;
        wr_en_d  = eff;
        new_d    = '0;
        old_d    = '0;
        except_d = |(retire_valid & retire_mispred);
        for (int i = 0; i < WAYS; i++) begin
            if (eff[i]) begin
                map_d[retire_arch[i]] = retire_phys[i];
                new_d[i]              = retire_phys[i];
                old_d[i]              = old_phys[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < ARCH; a++) begin
                map_q[a] <= phys_idx_t'(a);
            end
            wr_en_q  <= '0;
            new_q    <= '0;
            old_q    <= '0;
            except_q <= 1'b0;
        end else begin
            map_q    <= map_d;
            wr_en_q  <= wr_en_d;
            new_q    <= new_d;
            old_q    <= old_d;
            except_q <= except_d;
        end
    end

`ifdef RRAT_DUP_CHECK_EN
    logic            dup_err_q, dup_err_d;
    logic [ARCH-1:0] replaced;

    always_comb begin
        replaced = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (eff[i]) begin
                replaced[retire_arch[i]] = 1'b1;
            end
        end
        dup_err_d = dup_err_q;
        for (int i = 0; i < WAYS; i++) begin
            if (eff[i]) begin
                for (int a = 0; a < ARCH; a++) begin
                    if (!replaced[a] && (map_q[a] == retire_phys[i])) begin
                        dup_err_d = 1'b1;
                    end
                end
                for (int k = 0; k < WAYS; k++) begin
                    if ((k < i) && eff[k] && (retire_phys[k] == retire_phys[i])) begin
                        dup_err_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dup_err_q <= 1'b0;
        end else begin
            dup_err_q <= dup_err_d;
        end
    end

    assign dup_err = dup_err_q;
`endif

    assign wr_en_RRAT          = wr_en_q;
    assign reg_idx_wr_RRAT_new = new_q;
    assign reg_idx_wr_RRAT_old = old_q;
    assign except              = except_q;
    assign rrat_map            = map_q;
endmodule

// File: tb/tb_retire_rat.sv
// tb/tb_retire_rat.sv - directed self-checking bench for retire_rat
import rename_pkg::*;

module tb_retire_rat;
    logic                  clock;
    logic                  reset;
    logic [WAYS-1:0]       retire_valid;
    logic [WAYS-1:0]       retire_has_dest;
    arch_idx_t [WAYS-1:0]  retire_arch;
    phys_idx_t [WAYS-1:0]  retire_phys;
    logic [WAYS-1:0]       retire_mispred;
    logic [WAYS-1:0]       wr_en_RRAT;
    phys_idx_t [WAYS-1:0]  reg_idx_wr_RRAT_new;
    phys_idx_t [WAYS-1:0]  reg_idx_wr_RRAT_old;
    logic                  except;
`ifdef RRAT_DUP_CHECK_EN
    logic                  dup_err;
`endif
    map_t                  rrat_map;

    int checks = 0;
    int errors = 0;

    retire_rat dut (
        .clock               (clock),
        .reset               (reset),
        .retire_valid        (retire_valid),
        .retire_has_dest     (retire_has_dest),
        .retire_arch         (retire_arch),
        .retire_phys         (retire_phys),
        .retire_mispred      (retire_mispred),
        .wr_en_RRAT          (wr_en_RRAT),
        .reg_idx_wr_RRAT_new (reg_idx_wr_RRAT_new),
        .reg_idx_wr_RRAT_old (reg_idx_wr_RRAT_old),
        .except              (except),
`ifdef RRAT_DUP_CHECK_EN
        .dup_err             (dup_err),
`endif
        .rrat_map            (rrat_map)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        retire_valid    = '0;
        retire_has_dest = '0;
        retire_arch     = '0;
        retire_phys     = '0;
        retire_mispred  = '0;
    endtask

    task automatic set_way(input int w, input logic v, input logic d, input int a,
                           input int p, input logic m);
        retire_valid[w]    = v;
        retire_has_dest[w] = d;
        retire_arch[w]     = arch_idx_t'(a);
        retire_phys[w]     = phys_idx_t'(p);
        retire_mispred[w]  = m;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_en_RRAT !== 4'b0000) begin errors++; $display("FAIL reset_wr_en got %b exp 0000", wr_en_RRAT); end
        checks++; if (except !== 1'b0) begin errors++; $display("FAIL reset_except got %b exp 0", except); end
        checks++; if (reg_idx_wr_RRAT_new !== '0) begin errors++; $display("FAIL reset_new got %h exp 0", reg_idx_wr_RRAT_new); end
        checks++; if (reg_idx_wr_RRAT_old !== '0) begin errors++; $display("FAIL reset_old got %h exp 0", reg_idx_wr_RRAT_old); end
        for (int i = 0; i < ARCH; i++) begin
            checks++;
            if (rrat_map[i] !== phys_idx_t'(i)) begin
                errors++; $display("FAIL reset_map[%0d] got %0d exp %0d", i, rrat_map[i], i);
            end
        end
    endtask

    task automatic test_single();
        clear_inputs();
        set_way(0, 1, 1, 5, 40, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0001) begin errors++; $display("FAIL single_wr_en got %b exp 0001", wr_en_RRAT); end
        checks++; if (reg_idx_wr_RRAT_new[0] !== 6'd40) begin errors++; $display("FAIL single_new0 got %0d exp 40", reg_idx_wr_RRAT_new[0]); end
        checks++; if (reg_idx_wr_RRAT_old[0] !== 6'd5) begin errors++; $display("FAIL single_old0 got %0d exp 5", reg_idx_wr_RRAT_old[0]); end
        checks++; if (rrat_map[5] !== 6'd40) begin errors++; $display("FAIL single_map5 got %0d exp 40", rrat_map[5]); end
        checks++; if (except !== 1'b0) begin errors++; $display("FAIL single_except got %b exp 0", except); end
        clear_inputs();
        step();
        checks++; if (wr_en_RRAT !== 4'b0000) begin errors++; $display("FAIL idle_wr_en got %b exp 0000", wr_en_RRAT); end
        checks++; if (rrat_map[5] !== 6'd40) begin errors++; $display("FAIL idle_map5 got %0d exp 40", rrat_map[5]); end
    endtask

    task automatic test_collision();
        clear_inputs();
        set_way(0, 1, 1, 7, 33, 0);
        set_way(1, 1, 1, 7, 34, 0);
        set_way(2, 1, 1, 7, 35, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0111) begin errors++; $display("FAIL coll_wr_en got %b exp 0111", wr_en_RRAT); end
        checks++; if (reg_idx_wr_RRAT_old[0] !== 6'd7 || reg_idx_wr_RRAT_old[1] !== 6'd33 || reg_idx_wr_RRAT_old[2] !== 6'd34) begin
            errors++; $display("FAIL coll_old got %0d,%0d,%0d exp 7,33,34", reg_idx_wr_RRAT_old[0], reg_idx_wr_RRAT_old[1], reg_idx_wr_RRAT_old[2]); end
        checks++; if (reg_idx_wr_RRAT_new[0] !== 6'd33 || reg_idx_wr_RRAT_new[1] !== 6'd34 || reg_idx_wr_RRAT_new[2] !== 6'd35) begin
            errors++; $display("FAIL coll_new got %0d,%0d,%0d exp 33,34,35", reg_idx_wr_RRAT_new[0], reg_idx_wr_RRAT_new[1], reg_idx_wr_RRAT_new[2]); end
        checks++; if (rrat_map[7] !== 6'd35) begin errors++; $display("FAIL coll_map7 got %0d exp 35", rrat_map[7]); end
    endtask

    task automatic test_mispred();
        clear_inputs();
        set_way(0, 1, 1, 2, 41, 0);
        set_way(1, 1, 1, 1, 50, 1);
        set_way(2, 1, 1, 3, 51, 0);
        set_way(3, 1, 1, 4, 52, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0011) begin errors++; $display("FAIL mis_wr_en got %b exp 0011", wr_en_RRAT); end
        checks++; if (except !== 1'b1) begin errors++; $display("FAIL mis_except got %b exp 1", except); end
        checks++; if (rrat_map[1] !== 6'd50) begin errors++; $display("FAIL mis_map1 got %0d exp 50", rrat_map[1]); end
        checks++; if (rrat_map[2] !== 6'd41) begin errors++; $display("FAIL mis_map2 got %0d exp 41", rrat_map[2]); end
        checks++; if (rrat_map[3] !== 6'd3 || rrat_map[4] !== 6'd4) begin
            errors++; $display("FAIL mis_squashed_map got %0d,%0d exp 3,4", rrat_map[3], rrat_map[4]); end
        checks++; if (reg_idx_wr_RRAT_old[1] !== 6'd1 || reg_idx_wr_RRAT_old[0] !== 6'd2) begin
            errors++; $display("FAIL mis_old got %0d,%0d exp 2,1", reg_idx_wr_RRAT_old[0], reg_idx_wr_RRAT_old[1]); end
        checks++; if (reg_idx_wr_RRAT_new[2] !== 6'd0 || reg_idx_wr_RRAT_old[2] !== 6'd0) begin
            errors++; $display("FAIL mis_way2_out got new %0d old %0d exp 0,0", reg_idx_wr_RRAT_new[2], reg_idx_wr_RRAT_old[2]); end
        clear_inputs();
        step();
        checks++; if (except !== 1'b0) begin errors++; $display("FAIL mis_except_clear got %b exp 0", except); end
    endtask

    task automatic test_x0();
        clear_inputs();
        set_way(0, 1, 1, 0, 45, 0);
        set_way(1, 1, 1, 5, 46, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0010) begin errors++; $display("FAIL x0_wr_en got %b exp 0010", wr_en_RRAT); end
        checks++; if (rrat_map[0] !== 6'd0) begin errors++; $display("FAIL x0_map0 got %0d exp 0", rrat_map[0]); end
        checks++; if (reg_idx_wr_RRAT_old[1] !== 6'd40) begin errors++; $display("FAIL x0_old1 got %0d exp 40", reg_idx_wr_RRAT_old[1]); end
        checks++; if (rrat_map[5] !== 6'd46) begin errors++; $display("FAIL x0_map5 got %0d exp 46", rrat_map[5]); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        set_way(0, 1, 1, 6, 42, 0);
        step();
        checks++; if (reg_idx_wr_RRAT_old[0] !== 6'd6) begin errors++; $display("FAIL b2b_old_a got %0d exp 6", reg_idx_wr_RRAT_old[0]); end
        set_way(0, 1, 1, 6, 43, 0);
        step();
        checks++; if (reg_idx_wr_RRAT_old[0] !== 6'd42) begin errors++; $display("FAIL b2b_old_b got %0d exp 42", reg_idx_wr_RRAT_old[0]); end
        checks++; if (rrat_map[6] !== 6'd43) begin errors++; $display("FAIL b2b_map6 got %0d exp 43", rrat_map[6]); end
    endtask

    task automatic test_gap();
        clear_inputs();
        set_way(0, 1, 1, 8, 53, 0);
        set_way(1, 0, 1, 8, 55, 0);
        set_way(2, 1, 1, 8, 54, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0101) begin errors++; $display("FAIL gap_wr_en got %b exp 0101", wr_en_RRAT); end
        checks++; if (reg_idx_wr_RRAT_old[2] !== 6'd53) begin errors++; $display("FAIL gap_old2 got %0d exp 53", reg_idx_wr_RRAT_old[2]); end
        checks++; if (rrat_map[8] !== 6'd54) begin errors++; $display("FAIL gap_map8 got %0d exp 54", rrat_map[8]); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_way(0, 1, 1, 10, 56, 0);
        step();
        checks++; if (wr_en_RRAT !== 4'b0001) begin errors++; $display("FAIL ar_pre_wr_en got %b exp 0001", wr_en_RRAT); end
        set_way(0, 1, 1, 11, 57, 0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (wr_en_RRAT !== 4'b0000) begin errors++; $display("FAIL ar_now_wr_en got %b exp 0000", wr_en_RRAT); end
        checks++; if (rrat_map[10] !== 6'd10) begin errors++; $display("FAIL ar_now_map10 got %0d exp 10", rrat_map[10]); end
        checks++; if (reg_idx_wr_RRAT_new[0] !== 6'd0) begin errors++; $display("FAIL ar_now_new0 got %0d exp 0", reg_idx_wr_RRAT_new[0]); end
        step();
        reset = 1'b0;
        clear_inputs();
        step();
        checks++; if (wr_en_RRAT !== 4'b0000) begin errors++; $display("FAIL ar_after_wr_en got %b exp 0000", wr_en_RRAT); end
        checks++; if (rrat_map[11] !== 6'd11) begin errors++; $display("FAIL ar_after_map11 got %0d exp 11", rrat_map[11]); end
    endtask

`ifdef RRAT_DUP_CHECK_EN
    task automatic test_dup();
        do_reset();
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_reset got %b exp 0", dup_err); end
        set_way(0, 1, 1, 9, 3, 0);
        step();
        checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_set got %b exp 1", dup_err); end
        clear_inputs();
        step();
        step();
        checks++; if (dup_err !== 1'b1) begin errors++; $display("FAIL dup_sticky got %b exp 1", dup_err); end
        do_reset();
        checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL dup_cleared got %b exp 0", dup_err); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_collision();
        test_mispred();
        test_x0();
        test_back_to_back();
        test_gap();
        test_async_reset();
`ifdef RRAT_DUP_CHECK_EN
        test_dup();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
